golay24_enc_stream: RTL and testbench

GOLAY24_ENC_STREAM -- requirements
Module: golay24_enc_stream

---
 rtl/golay24_enc_stream_pkg.sv | 25 ++
 rtl/golay24_enc_stream_if.sv | 37 +++
 rtl/golay24_enc_lane.sv | 15 +
 rtl/golay24_enc_stream.sv | 128 ++++++++++++
 tb/tb_golay24_enc_stream.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/golay24_enc_stream_pkg.sv
// Shared Golay(24,12)/(23,12) constants, frame FSM type and the syndrome helper
// used by every lane encoder.
package golay24_enc_stream_pkg;

  localparam int          DATA_W   = 12;
  localparam int          CW_W     = 24;
  localparam logic [11:0] GEN_POLY = 12'hC75;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } frame_state_t;

  // Bits [10:0]: remainder of v[23:1] modulo the generator.
  // Bit 11: overall parity, chosen so that {syndrome, data} has even weight.
  function automatic logic [11:0] get_syndrome(input logic [CW_W-1:0] v);
    logic [22:0] rem;
    rem = v[CW_W-1:1];
    for (int i = 22; i >= 11; i--) begin
      if (rem[i]) rem[i -: 12] = rem[i -: 12] ^ GEN_POLY;
    end
    return {(^v) ^ (^rem[10:0]), rem[10:0]};
  endfunction

endpackage

// File: rtl/golay24_enc_stream_if.sv
// Beat stream bundle: input beat with handshake, encoded output beat with handshake.
interface golay24_enc_stream_if
  import golay24_enc_stream_pkg::*;
#(
  parameter int pLANE_N = 1,
  parameter int pTAG_W  = 1,
  parameter int pCNT_W  = 16
);

  logic                        ival;
  logic                        isop;
  logic                        ieop;
  logic                        imode;
  logic [pTAG_W-1:0]           itag;
  logic [DATA_W*pLANE_N-1:0]   idat;
  logic                        ordy;

  logic                        oval;
  logic                        osop;
  logic                        oeop;
  logic                        oerr;
  logic [pTAG_W-1:0]           otag;
  logic [CW_W*pLANE_N-1:0]     odat;
  logic [pCNT_W-1:0]           ocnt;
  logic                        irdy;

  modport master (
    output ival, isop, ieop, imode, itag, idat, irdy,
    input  ordy, oval, osop, oeop, oerr, otag, odat, ocnt
  );

  modport slave (
    input  ival, isop, ieop, imode, itag, idat, irdy,
    output ordy, oval, osop, oeop, oerr, otag, odat, ocnt
  );

endinterface

// File: rtl/golay24_enc_lane.sv
// One 12-bit lane encoder; mode 1 drops the overall parity bit (perfect code).
module golay24_enc_lane
  import golay24_enc_stream_pkg::*;
(
  input  logic [DATA_W-1:0] idat,
  input  logic              imode,
  output logic [CW_W-1:0]   odat
);

  logic [11:0] syn;

  assign syn  = get_syndrome({idat, 12'h000});
  assign odat = {syn[11] & ~imode, syn[10:0], idat};

endmodule

// File: rtl/golay24_enc_stream.sv
// Streaming multi-lane Golay encoder: S1 captures the beat and frame status,
// S2 holds the encoded beat until the downstream accepts it.
module golay24_enc_stream
  import golay24_enc_stream_pkg::*;
#(
  parameter int pLANE_N = 1,
  parameter int pTAG_W  = 1,
  parameter int pCNT_W  = 16
)(
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  golay24_enc_stream_if.slave bus
);

  frame_state_t              state_q, state_d;
  logic [pCNT_W-1:0]         cnt_q, beat_cnt;
  logic                      beat_err;

  logic                      s1_adv, s2_adv, in_xfer;

  logic                      s1_val, s1_err, s1_sop, s1_eop, s1_mode;
  logic [pTAG_W-1:0]         s1_tag;
  logic [pCNT_W-1:0]         s1_cnt;
  logic [DATA_W*pLANE_N-1:0] s1_dat;

  logic                      s2_val, s2_err, s2_sop, s2_eop;
  logic [pTAG_W-1:0]         s2_tag;
  logic [pCNT_W-1:0]         s2_cnt;
  logic [CW_W*pLANE_N-1:0]   s2_dat;

  logic [CW_W*pLANE_N-1:0]   enc_dat;

  // A stage can take new contents when it is empty or its contents move on.
  assign s2_adv   = ~s2_val | bus.irdy;
  assign s1_adv   = ~s1_val | s2_adv;
  assign bus.ordy = iclkena & s1_adv;
  assign in_xfer  = bus.ival & bus.ordy;

  // Frame tracking: state and beat counter move together on each accepted beat.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (in_xfer) begin
      state_q <= state_d;
      cnt_q   <= beat_cnt;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (bus.isop && !bus.ieop) state_d = ST_IN_FRAME;
      ST_IN_FRAME: if (bus.ieop)              state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // NOTE: every variable gets a default at the top of a combinational block so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    beat_err = 1'b0;
    beat_cnt = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    if (bus.isop) begin
      beat_cnt = '0;
      beat_err = (state_q == ST_IN_FRAME);
    end else if (state_q == ST_IDLE) begin
      beat_cnt = '0;
      beat_err = 1'b1;
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      s1_val <= 1'b0;
      s1_err <= 1'b0;
      s2_val <= 1'b0;
      s2_err <= 1'b0;
    end else if (iclkena) begin
      if (s1_adv) begin
        s1_val <= bus.ival;
        s1_err <= bus.ival & beat_err;
      end
      if (s2_adv) begin
        s2_val <= s1_val;
        s2_err <= s1_val & s1_err;
      end
    end
  end

  // NOTE: datapath registers have no reset; they are only observed while the
  // matching valid bit is set, and the valids are reset.
  always_ff @(posedge iclk) begin
    if (in_xfer) begin
      s1_sop  <= bus.isop;
      s1_eop  <= bus.ieop;
      s1_mode <= bus.imode;
      s1_tag  <= bus.itag;
      s1_cnt  <= beat_cnt;
      s1_dat  <= bus.idat;
    end
    if (iclkena && s2_adv && s1_val) begin
      s2_sop <= s1_sop;
      s2_eop <= s1_eop;
      s2_tag <= s1_tag;
      s2_cnt <= s1_cnt;
      s2_dat <= enc_dat;
    end
  end

  for (genvar k = 0; k < pLANE_N; k++) begin : g_lane
    golay24_enc_lane u_lane (
      .idat  (s1_dat[DATA_W*k +: DATA_W]),
      .imode (s1_mode),
      .odat  (enc_dat[CW_W*k +: CW_W])
    );
  end

  assign bus.oval = s2_val;
  assign bus.oerr = s2_err;
  assign bus.osop = s2_sop;
  assign bus.oeop = s2_eop;
  assign bus.otag = s2_tag;
  assign bus.ocnt = s2_cnt;
  assign bus.odat = s2_dat;

endmodule

// File: tb/tb_golay24_enc_stream.sv
// Self-checking bench for golay24_enc_stream: known-codeword table, frame
// sequences, saturation, random backpressure, clock-enable freeze and reset.
module tb_golay24_enc_stream;

  localparam int L  = 4;
  localparam int TW = 8;
  localparam int CB = 3;

  typedef struct {
    logic [12*L-1:0] dat;
    logic            mode;
    logic [TW-1:0]   tag;
    logic            sop;
    logic            eop;
    logic [CB-1:0]   cnt;
    logic            err;
  } exp_t;

  typedef struct {
    logic            mode;
    logic [12*L-1:0] dat;
    logic [24*L-1:0] cw;
  } vec_t;

  logic iclk    = 1'b0;
  logic ireset  = 1'b1;
  logic iclkena = 1'b1;

  golay24_enc_stream_if #(.pLANE_N(L), .pTAG_W(TW), .pCNT_W(CB)) bus ();

  golay24_enc_stream #(.pLANE_N(L), .pTAG_W(TW), .pCNT_W(CB)) dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .bus     (bus.slave)
  );

  always #5 iclk = ~iclk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic [CB-1:0] obs_cnt[$];
  logic          obs_err[$];
  logic m_in  = 1'b0;
  logic [CB-1:0] m_cnt = '0;
  logic rnd_irdy = 1'b0;
  logic          prev_stall = 1'b0;
  logic [127:0]  prev_vec;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Remainder of a 23-bit polynomial modulo x^11+x^10+x^6+x^5+x^4+x^2+1, bit-serial.
  function automatic logic [10:0] poly_rem(input logic [22:0] c);
    logic [10:0] r;
    logic        msb;
    r = '0;
    for (int i = 22; i >= 0; i--) begin
      msb = r[10];
      r   = {r[9:0], c[i]};
      if (msb) r = r ^ 11'h475;
    end
    return r;
  endfunction

  function automatic logic [127:0] out_vec();
    return 128'({bus.oval, bus.osop, bus.oeop, bus.oerr, bus.ocnt, bus.otag, bus.odat});
  endfunction

  // Scoreboard: pop on output transfer, push on input transfer, hold-check on stall.
  always @(negedge iclk) begin
    if (ireset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", out_vec(), prev_vec);
      if (bus.oval && bus.irdy && iclkena) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got odat %0h expected no beat", bus.odat);
        end else begin
          exp_t e;
          e = sb.pop_front();
          obs_cnt.push_back(bus.ocnt);
          obs_err.push_back(bus.oerr);
          check("frame_fields", {bus.otag, bus.osop, bus.oeop, bus.ocnt, bus.oerr},
                {e.tag, e.sop, e.eop, e.cnt, e.err});
          for (int k = 0; k < L; k++) begin
            logic [23:0] cw;
            logic [11:0] d;
            cw = bus.odat[24*k +: 24];
            d  = e.dat[12*k +: 12];
            check("lane_data", cw[11:0], d);
            check("lane_divisible", poly_rem({cw[11:0], cw[22:12]}), 0);
            check("lane_bit23", cw[23], e.mode ? 1'b0 : ^cw[22:0]);
            if (d != 0)
              check("lane_min_weight", ($countones(cw) >= (e.mode ? 7 : 8)), 1);
          end
        end
      end
      if (bus.ival && bus.ordy && iclkena) begin
        exp_t e;
        e.dat = bus.idat; e.mode = bus.imode; e.tag = bus.itag;
        e.sop = bus.isop; e.eop = bus.ieop;
        if (bus.isop) begin
          e.cnt = '0; e.err = m_in; m_in = ~bus.ieop;
        end else if (!m_in) begin
          e.cnt = '0; e.err = 1'b1;
        end else begin
          e.cnt = (m_cnt == 3'd7) ? m_cnt : m_cnt + 3'd1;
          e.err = 1'b0; m_in = ~bus.ieop;
        end
        m_cnt = e.cnt;
        sb.push_back(e);
      end
      prev_stall = bus.oval && !(bus.irdy && iclkena);
      prev_vec   = out_vec();
    end
  end

  task automatic send(input logic sop, input logic eop, input logic mode,
                      input logic [12*L-1:0] dat, input logic [TW-1:0] tag, output int tries);
    logic acc;
    acc = 1'b0;
    tries = 0;
    bus.ival = 1'b1; bus.isop = sop; bus.ieop = eop;
    bus.imode = mode; bus.idat = dat; bus.itag = tag;
    for (int i = 0; i < 40; i++) begin
      @(negedge iclk);
      acc = bus.ordy & iclkena;
      tries++;
      @(posedge iclk); #1;
      if (rnd_irdy) bus.irdy = 1'($urandom_range(0, 1));
      if (acc) break;
    end
    check("send_accept", acc, 1);
  endtask

  task automatic idle();
    bus.ival = 1'b0; bus.isop = 1'b0; bus.ieop = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge iclk);
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic check_obs(input string name, input logic [CB-1:0] ec[], input logic ee[]);
    check({name, "_count"}, obs_cnt.size(), ec.size());
    if (obs_cnt.size() == ec.size()) begin
      for (int i = 0; i < ec.size(); i++) begin
        check({name, "_ocnt"}, obs_cnt[i], ec[i]);
        check({name, "_oerr"}, obs_err[i], ee[i]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int   tries;
    logic [127:0] snap;

    vecs[0] = '{1'b0, 48'h0, 96'h0};
    vecs[1] = '{1'b0, {12'hFFF, 12'hC75, 12'h001, 12'hC74},
                {24'hFFFFFF, 24'h800C75, 24'hC75001, 24'h475C74}};
    vecs[2] = '{1'b1, {12'hFFF, 12'hC75, 12'h001, 12'hC74},
                {24'h7FFFFF, 24'h000C75, 24'h475001, 24'h475C74}};
    vecs[3] = '{1'b0, {12'hFFE, 12'h000, 12'hFFF, 12'h001},
                {24'h38AFFE, 24'h000000, 24'hFFFFFF, 24'hC75001}};
    vecs[4] = '{1'b1, {12'h001, 12'h001, 12'h001, 12'h001},
                {24'h475001, 24'h475001, 24'h475001, 24'h475001}};

    bus.irdy = 1'b1; bus.imode = 1'b0; bus.itag = '0; bus.idat = '0;
    idle();
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    check("reset_oval", bus.oval, 0);
    check("reset_oerr", bus.oerr, 0);
    @(posedge iclk); #1 ireset = 1'b0;
    @(negedge iclk);
    check("ordy_after_reset", bus.ordy, 1);
    @(posedge iclk); #1;

    // Known codewords, single-beat frames, exact two-cycle latency.
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b1, vecs[i].mode, vecs[i].dat, TW'(i), tries);
      idle();
      @(negedge iclk);
      check("tbl_latency_early", bus.oval, 0);
      @(posedge iclk); #1;
      @(negedge iclk);
      check("tbl_oval", bus.oval, 1);
      check("tbl_odat", bus.odat, vecs[i].cw);
      check("tbl_oerr_ocnt", {bus.oerr, bus.ocnt}, 0);
      @(posedge iclk); #1;
    end
    drain();

    // Frame sequences: 5-beat, single, restart mid-frame, orphan. Back-to-back.
    obs_cnt.delete(); obs_err.delete();
    for (int i = 0; i < 5; i++) begin
      send(i == 0, i == 4, 1'b0, {4{12'(i * 37)}}, TW'(8'h10 + i), tries);
      check("no_bubble", tries, 1);
    end
    send(1'b1, 1'b1, 1'b1, {4{12'hA5A}}, 8'h20, tries);
    send(1'b1, 1'b0, 1'b0, {4{12'h123}}, 8'h21, tries);
    send(1'b0, 1'b0, 1'b0, {4{12'h456}}, 8'h22, tries);
    send(1'b1, 1'b0, 1'b1, {4{12'h789}}, 8'h23, tries);
    send(1'b0, 1'b1, 1'b0, {4{12'hABC}}, 8'h24, tries);
    send(1'b0, 1'b0, 1'b0, {4{12'hDEF}}, 8'h25, tries);
    idle();
    drain();
    check_obs("frames", '{0, 1, 2, 3, 4, 0, 0, 1, 0, 1, 0},
                        '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1});

    // Counter saturation at 7.
    obs_cnt.delete(); obs_err.delete();
    for (int i = 0; i < 10; i++)
      send(i == 0, i == 9, 1'b0, {4{12'(i + 1)}}, TW'(i), tries);
    idle();
    drain();
    check_obs("saturate", '{0, 1, 2, 3, 4, 5, 6, 7, 7, 7}, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

    // Continuous random stream with random backpressure.
    rnd_irdy = 1'b1;
    for (int i = 0; i < 600; i++)
      send($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
           {$urandom(), 16'($urandom())}, TW'($urandom()), tries);
    idle();
    rnd_irdy = 1'b0;
    bus.irdy = 1'b1;
    drain();

    // Clock-enable freeze mid-stream.
    for (int i = 0; i < 3; i++) send(i == 0, 1'b0, 1'b0, {4{12'(i + 100)}}, TW'(i), tries);
    bus.ival = 1'b1; bus.isop = 1'b0; bus.idat = {4{12'h3C3}}; bus.itag = 8'h77;
    iclkena = 1'b0;
    snap = out_vec();
    for (int i = 0; i < 3; i++) begin
      @(negedge iclk);
      check("freeze_ordy", bus.ordy, 0);
      check("freeze_outputs", out_vec(), snap);
      @(posedge iclk); #1;
    end
    iclkena = 1'b1;
    send(1'b0, 1'b0, 1'b0, {4{12'h3C3}}, 8'h77, tries);
    send(1'b0, 1'b1, 1'b1, {4{12'h5A5}}, 8'h78, tries);
    idle();
    drain();

    // Reset with beats in flight, then an orphan beat.
    bus.irdy = 1'b0;
    send(1'b1, 1'b0, 1'b0, {4{12'h111}}, 8'h90, tries);
    send(1'b0, 1'b0, 1'b0, {4{12'h222}}, 8'h91, tries);
    idle();
    #2 ireset = 1'b1;
    sb.delete();
    m_in = 1'b0; m_cnt = '0;
    @(negedge iclk);
    check("reset_flush_oval", bus.oval, 0);
    @(posedge iclk); #1 ireset = 1'b0;
    bus.irdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge iclk);
      check("no_stale_beat", bus.oval, 0);
    end
    @(posedge iclk); #1;
    obs_cnt.delete(); obs_err.delete();
    send(1'b0, 1'b0, 1'b0, {4{12'h333}}, 8'h92, tries);
    idle();
    drain();
    check_obs("orphan_after_reset", '{0}, '{1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
